serial_adder_n: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 8 +
 rtl/serial_adder_n_fa_cell.sv | 13 +
 rtl/serial_adder_n.sv | 137 +++++++++++++
 tb/tb_serial_adder_n.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and limits for the bit-serial adder.
package serial_adder_pkg;

   localparam int MAX_WIDTH = 32;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} sa_state_t;

endpackage

// File: rtl/serial_adder_n_fa_cell.sv
// Single-bit full-adder cell reused once per clock by the serial adder.
module fa_cell (
   input  logic x,
   input  logic y,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = x ^ y ^ ci;
   assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_adder_n.sv
// WIDTH-bit bit-serial ripple adder with start/busy/done handshake.
// Define SERIAL_ADDER_SUB_EN to add the sub port (a - b via ~b and carry-in 1).
module serial_adder_n
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int              CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
      $error("serial_adder_n: WIDTH out of range 1..MAX_WIDTH");
   end

   sa_state_t        state_q, state_d;
   logic [WIDTH-1:0] sha_q, sha_d;
   logic [WIDTH-1:0] shb_q, shb_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic             fa_s, fa_co;
   logic [WIDTH-1:0] res_shift;
   logic [WIDTH-1:0] b_load;
   logic             c_load;

`ifdef SERIAL_ADDER_SUB_EN
   assign b_load = sub ? ~b : b;
   assign c_load = sub ? 1'b1 : cin;
`else
   assign b_load = b;
   assign c_load = cin;
`endif

   fa_cell u_fa (
      .x  (sha_q[0]),
      .y  (shb_q[0]),
      .ci (carry_q),
      .s  (fa_s),
      .co (fa_co)
   );

   // New bit enters at the MSB; written as a shift so WIDTH = 1 needs no special slice.
   assign res_shift = (res_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

   always_comb begin
      // NOTE: every next-state signal gets its hold value first so no path infers a latch.
      state_d = state_q;
      sha_d   = sha_q;
      shb_d   = shb_q;
      res_d   = res_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;

      unique case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start) begin
               sha_d   = a;
               shb_d   = b_load;
               carry_d = c_load;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            sha_d   = sha_q >> 1;
            shb_d   = shb_q >> 1;
            res_d   = res_shift;
            carry_d = fa_co;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == LAST) begin
               sum_d   = res_shift;
               cout_d  = fa_co;
               ovf_d   = fa_co ^ carry_q;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: the datapath registers are reset too, so no stale operand survives an aborted operation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sha_q   <= '0;
         shb_q   <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking updates so every register sees pre-edge values of the others.
         state_q <= state_d;
         sha_q   <= sha_d;
         shb_q   <= shb_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy = (state_q == SHIFT);
   assign done = (state_q == DONE);
   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_n.sv
// Self-checking bench for serial_adder_n: directed table, corner sequences, random vs. arithmetic model.
module tb_serial_adder_n;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;
`ifdef SERIAL_ADDER_SUB_EN
   logic         sub;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   serial_adder_n #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
`ifdef SERIAL_ADDER_SUB_EN
      .sub   (sub),
`endif
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout),
      .ovf   (ovf)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [W-1:0] va;
      logic [W-1:0] vb;
      logic         vcin;
      logic         vsub;
      logic [W-1:0] esum;
      logic         ecout;
      logic         eovf;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic, signed overflow from the true signed result range.
   function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                          input logic mc, input logic ms);
      logic [W-1:0] eb;
      longint       ec, u, sa, sb, sres;
      logic         mov, mco;
      eb   = ms ? ~mb : mb;
      ec   = ms ? 1 : longint'(mc);
      u    = longint'(ma) + longint'(eb) + ec;
      sa   = longint'(ma) - (ma[W-1] ? (longint'(1) << W) : 0);
      sb   = longint'(eb) - (eb[W-1] ? (longint'(1) << W) : 0);
      sres = sa + sb + ec;
      mov  = (sres > ((longint'(1) << (W - 1)) - 1)) || (sres < -(longint'(1) << (W - 1)));
      mco  = (u >= (longint'(1) << W));
      return {mov, mco, u[W-1:0]};
   endfunction

   // Called just after a negedge; drives start for one cycle and checks the whole transaction.
   task automatic run_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tbv,
                         input logic tcin, input logic [W-1:0] es, input logic ec, input logic eo);
      logic [W-1:0] held;
      int lat, busy_cnt, sum_moves;
      held  = sum;
      a     = ta;
      b     = tbv;
      cin   = tcin;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a     = W'($urandom);
      b     = W'($urandom);
      cin   = 1'($urandom);
      lat = 1; busy_cnt = 0; sum_moves = 0;
      while (!done && lat <= W + 4) begin
         if (busy) busy_cnt++;
         if (sum !== held) sum_moves++;
         @(negedge clk);
         lat++;
      end
      check({name, "_done_seen"}, done, 1);
      check({name, "_latency"}, lat, W + 1);
      check({name, "_busy_cycles"}, busy_cnt, W);
      check({name, "_sum_held"}, sum_moves, 0);
      check({name, "_busy_at_done"}, busy, 0);
      check({name, "_sum"}, sum, es);
      check({name, "_cout"}, cout, ec);
      check({name, "_ovf"}, ovf, eo);
   endtask

   initial begin
      logic [W+1:0] m;
      logic [W-1:0] ra, rb, got_sum;
      logic         rc, rs;
      int           dcount, first;

      rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      sub = 1'b0;
`endif

      vecs.push_back('{8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1});
      vecs.push_back('{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0});
      vecs.push_back('{8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1});
      vecs.push_back('{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0});
      vecs.push_back('{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1});
      vecs.push_back('{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
`ifdef SERIAL_ADDER_SUB_EN
      vecs.push_back('{8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0});
      vecs.push_back('{8'h20, 8'h10, 1'b0, 1'b1, 8'h10, 1'b1, 1'b0});
      vecs.push_back('{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1});
`endif

      repeat (3) @(negedge clk);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_sum", sum, 0);
      check("reset_cout", cout, 0);
      check("reset_ovf", ovf, 0);
      rst = 1'b0;
      @(negedge clk);

      foreach (vecs[i]) begin
`ifdef SERIAL_ADDER_SUB_EN
         sub = vecs[i].vsub;
`endif
         run_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].vcin,
                vecs[i].esum, vecs[i].ecout, vecs[i].eovf);
         @(negedge clk);
         check($sformatf("vec%0d_single_pulse", i), done, 0);
         check($sformatf("vec%0d_sum_stable", i), sum, vecs[i].esum);
      end
`ifdef SERIAL_ADDER_SUB_EN
      sub = 1'b0;
`endif

      // Start during SHIFT must be ignored: 0x11 + 0x22 completes, one done pulse.
      a = 8'h11; b = 8'h22; cin = 1'b0; start = 1'b1;
      @(negedge clk);
      dcount = 0; first = 0; got_sum = '0;
      for (int k = 1; k <= 2 * W + 4; k++) begin
         if (k == 3) begin
            start = 1'b1;
            a     = 8'hF0;
         end else begin
            start = 1'b0;
         end
         if (done) begin
            dcount++;
            if (first == 0) begin
               first   = k;
               got_sum = sum;
            end
         end
         @(negedge clk);
      end
      check("ignore_start_done_count", dcount, 1);
      check("ignore_start_latency", first, W + 1);
      check("ignore_start_sum", got_sum, 8'h33);

      // Reset at busy cycle 4 aborts the operation with no done pulse.
      a = 8'h40; b = 8'h01; cin = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("abort_busy_before_rst", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_sum", sum, 0);
      check("abort_cout", cout, 0);
      check("abort_ovf", ovf, 0);
      rst = 1'b0;
      dcount = 0;
      for (int k = 0; k < 2 * W; k++) begin
         if (done || busy) dcount++;
         @(negedge clk);
      end
      check("abort_no_activity", dcount, 0);
      run_op("after_abort", 8'h21, 8'h43, 1'b0, 8'h64, 1'b0, 1'b0);

      // Back-to-back: start held through DONE; second done WIDTH+1 cycles after the first.
      @(negedge clk);
      run_op("b2b_first", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
      run_op("b2b_second", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

      // Random operands against the arithmetic model, mixing idle gaps and back-to-back starts.
      for (int i = 0; i < 40; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rc = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
         rs  = 1'($urandom);
         sub = rs;
`else
         rs = 1'b0;
`endif
         m = model(ra, rb, rc, rs);
         run_op($sformatf("rand%0d", i), ra, rb, rc, m[W-1:0], m[W], m[W+1]);
         if ($urandom_range(1, 0) == 1) @(negedge clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
